// File: rtl/matmul_stream_loader.sv
// Stream front end for the systolic matmul scheduler: packs A/B element streams into flat buses,
// pulses START, captures C on GLOBAL_DONE and drains it back out as a valid/ready/last stream.
module matmul_stream_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int SIZE       = 6,
    parameter int ARRAY_SIZE = SIZE*SIZE
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cmd_start,
    input  logic [3:0]                       cfg_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH-1:0]            in_data,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] A_matrix,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] B_matrix,
    output logic                             START,
    input  logic                             GLOBAL_DONE,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] C_matrix,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_last,
    output logic                             busy,
    output logic                             done,
    output logic                             err
);

    localparam int BUS_W = ARRAY_SIZE*DATA_WIDTH;
    localparam logic [3:0] SIZE_N = 4'(SIZE);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_KICK   = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_DRAIN  = 3'd5;

    // Element 0 sits at the MSB end of the flat bus.
    function automatic logic [DATA_WIDTH-1:0] get_slot(input logic [BUS_W-1:0] bus, input int e);
        return bus[(ARRAY_SIZE-e)*DATA_WIDTH-1 -: DATA_WIDTH];
    endfunction

    logic [2:0]            state_q, state_d;
    logic [3:0]            row_q, row_d, col_q, col_d, n_q, n_d;
    logic [BUS_W-1:0]      a_q, a_d, b_q, b_d, cbuf_q, cbuf_d;
    logic [DATA_WIDTH-1:0] odata_q, odata_d;
    logic                  olast_q, olast_d, done_q, done_d, err_q, err_d;

    logic       beat, at_end;
    logic [3:0] nxt_row, nxt_col;
    int         e_rc, e_cr, e_nxt;

    assign in_ready  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
    assign START     = (state_q == S_KICK);
    assign out_valid = (state_q == S_DRAIN);
    assign busy      = (state_q != S_IDLE);
    assign A_matrix  = a_q;
    assign B_matrix  = b_q;
    assign out_data  = odata_q;
    assign out_last  = olast_q;
    assign done      = done_q;
    assign err       = err_q;
    assign beat      = in_valid && in_ready;

    // Shared row-major walker for both load phases and the drain; wraps to (0,0) after the last element.
    always_comb begin
        at_end = (row_q == n_q - 4'd1) && (col_q == n_q - 4'd1);
        if (at_end) begin
            nxt_row = 4'd0;
            nxt_col = 4'd0;
        end else if (col_q == n_q - 4'd1) begin
            nxt_row = row_q + 4'd1;
            nxt_col = 4'd0;
        end else begin
            nxt_row = row_q;
            nxt_col = col_q + 4'd1;
        end
        e_rc  = int'(row_q) * SIZE + int'(col_q);
        e_cr  = int'(col_q) * SIZE + int'(row_q);
        e_nxt = int'(nxt_row) * SIZE + int'(nxt_col);
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        n_d     = n_q;
        a_d     = a_q;
        b_d     = b_q;
        cbuf_d  = cbuf_q;
        odata_d = odata_q;
        olast_d = olast_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // The done cycle still counts as part of the finished job, so commands wait one cycle.
                if (cmd_start && !done_q) begin
                    if (cfg_n != 4'd0 && cfg_n <= SIZE_N) begin
                        n_d     = cfg_n;
                        a_d     = '0;
                        b_d     = '0;
                        row_d   = 4'd0;
                        col_d   = 4'd0;
                        state_d = S_LOAD_A;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD_A: begin
                if (beat) begin
                    a_d[(ARRAY_SIZE-e_rc)*DATA_WIDTH-1 -: DATA_WIDTH] = in_data;
                    row_d = nxt_row;
                    col_d = nxt_col;
                    if (at_end) state_d = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                if (beat) begin
                    b_d[(ARRAY_SIZE-e_cr)*DATA_WIDTH-1 -: DATA_WIDTH] = in_data;
                    row_d = nxt_row;
                    col_d = nxt_col;
                    if (at_end) state_d = S_KICK;
                end
            end
            S_KICK: state_d = S_WAIT;
            S_WAIT: begin
                if (GLOBAL_DONE) begin
                    cbuf_d  = C_matrix;
                    odata_d = get_slot(C_matrix, 0);
                    olast_d = (n_q == 4'd1);
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    row_d = nxt_row;
                    col_d = nxt_col;
                    if (olast_q) begin
                        odata_d = '0;
                        olast_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        odata_d = get_slot(cbuf_q, e_nxt);
                        olast_d = (nxt_row == n_q - 4'd1) && (nxt_col == n_q - 4'd1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            n_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cbuf_q  <= '0;
            odata_q <= '0;
            olast_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            n_q     <= n_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cbuf_q  <= cbuf_d;
            odata_q <= odata_d;
            olast_q <= olast_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_matmul_stream_loader.sv
// Directed bench for matmul_stream_loader: load/kick/capture/drain jobs, illegal configs,
// mid-job reset and ignored commands while busy.
module tb_matmul_stream_loader;

    localparam int DW = 32;
    localparam int SZ = 6;
    localparam int AS = SZ*SZ;
    localparam int BW = AS*DW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_start = 1'b0;
    logic [3:0]    cfg_n = 4'd0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [BW-1:0] A_matrix, B_matrix;
    logic          START;
    logic          GLOBAL_DONE = 1'b0;
    logic [BW-1:0] C_matrix = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last, busy, done, err;

    matmul_stream_loader #(.DATA_WIDTH(DW), .SIZE(SZ)) dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cfg_n(cfg_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .A_matrix(A_matrix), .B_matrix(B_matrix), .START(START),
        .GLOBAL_DONE(GLOBAL_DONE), .C_matrix(C_matrix),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int in_beats = 0, out_beats = 0, start_cnt = 0;

    always @(posedge clk) begin
        if (in_valid && in_ready) in_beats <= in_beats + 1;
        if (out_valid && out_ready) out_beats <= out_beats + 1;
        if (START) start_cnt <= start_cnt + 1;
    end

    logic [DW-1:0] stream [2*AS];
    logic [DW-1:0] ea [AS];
    logic [DW-1:0] eb [AS];
    logic [DW-1:0] expc [AS];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] slot(input logic [BW-1:0] bus, input int e);
        return bus[(AS-e)*DW-1 -: DW];
    endfunction

    // A(r,c)=abase+r*n+c, B(r,c)=bbase+r*n+c; expected slots derived from the packing rule.
    task automatic prep(input int n, input int abase, input int bbase, input int cbase);
        for (int e = 0; e < AS; e++) begin
            ea[e] = '0; eb[e] = '0; expc[e] = '0;
        end
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                stream[r*n+c]       = 32'(abase + r*n + c);
                stream[n*n + r*n+c] = 32'(bbase + r*n + c);
                ea[r*SZ+c]          = 32'(abase + r*n + c);
                eb[c*SZ+r]          = 32'(bbase + r*n + c);
                expc[r*n+c]         = 32'(cbase + r*n + c);
            end
    endtask

    function automatic logic [BW-1:0] c_bus(input int n, input logic [DW-1:0] fill);
        logic [BW-1:0] b;
        b = '0;
        for (int e = 0; e < AS; e++) b[(AS-e)*DW-1 -: DW] = fill + 32'(e);
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                b[(AS-(r*SZ+c))*DW-1 -: DW] = expc[r*n+c];
        return b;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_job(input logic [3:0] n);
        cmd_start = 1'b1;
        cfg_n     = n;
        @(negedge clk);
        cmd_start = 1'b0;
    endtask

    task automatic load(input int total, input bit rnd);
        int idx = 0;
        int cyc = 0;
        while (idx < total && cyc < 2000) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = stream[idx];
            if (in_valid && in_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk("load_beats", 32'(idx), 32'(total));
    endtask

    task automatic check_ab(input string tag);
        for (int e = 0; e < AS; e++) begin
            chk($sformatf("%s_A%0d", tag, e), slot(A_matrix, e), ea[e]);
            chk($sformatf("%s_B%0d", tag, e), slot(B_matrix, e), eb[e]);
        end
    endtask

    // Entered on the KICK cycle; leaves on the first DRAIN cycle.
    task automatic kick_wait(input int n, input int wdelay, input bit inject);
        chk("start_hi", 32'(START), 32'd1);
        @(negedge clk);
        chk("start_lo", 32'(START), 32'd0);
        chk("wait_busy", 32'(busy), 32'd1);
        if (inject) begin
            cmd_start = 1'b1;
            cfg_n     = 4'd2;
        end
        repeat (wdelay) @(negedge clk);
        cmd_start   = 1'b0;
        GLOBAL_DONE = 1'b1;
        C_matrix    = c_bus(n, 32'hDEAD0000);
        @(negedge clk);
        chk("drain_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic drain(input int n, input bit rnd, input bit inject);
        int k = 0;
        int cyc = 0;
        bit stalled = 0;
        logic [DW-1:0] pdata;
        logic plast;
        int total = n*n;
        while (k < total && cyc < 2000) begin
            out_ready = rnd ? ($urandom_range(0, 3) == 0) : 1'b1;
            cmd_start = inject && (cyc == 2);
            cfg_n     = 4'd2;
            if (out_valid) begin
                if (stalled) begin
                    chk("stall_data", out_data, pdata);
                    chk("stall_last", 32'(out_last), 32'(plast));
                end
                if (out_ready) begin
                    chk($sformatf("out%0d", k), out_data, expc[k]);
                    chk($sformatf("last%0d", k), 32'(out_last), 32'(k == total-1));
                    k++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    pdata = out_data;
                    plast = out_last;
                end
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        cmd_start = 1'b0;
        chk("drain_count", 32'(k), 32'(total));
        chk("done_hi", 32'(done), 32'd1);
        chk("done_ov", 32'(out_valid), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
        GLOBAL_DONE = 1'b0;
        @(negedge clk);
        chk("done_lo", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic job(input int n, input bit rin, input bit rout, input int wdelay, input bit inject);
        int ib, ob, sc;
        ib = in_beats; ob = out_beats; sc = start_cnt;
        start_job(4'(n));
        chk("job_busy", 32'(busy), 32'd1);
        load(2*n*n, rin);
        check_ab($sformatf("n%0d", n));
        kick_wait(n, wdelay, inject);
        // Scheduler result changes after capture; the buffer must not follow it.
        C_matrix = c_bus(n, 32'h5A5A0000) ^ {AS{32'hFFFF_FFFF}};
        drain(n, rout, inject);
        chk("in_beats", 32'(in_beats - ib), 32'(2*n*n));
        chk("out_beats", 32'(out_beats - ob), 32'(n*n));
        chk("start_cnt", 32'(start_cnt - sc), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int sc;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_A", 32'(A_matrix == '0), 32'd1);
        do_reset();
        chk("idle_ready", 32'(in_ready), 32'd0);
        chk("idle_ov", 32'(out_valid), 32'd0);

        // 1: 2x2 worked example.
        prep(2, 1, 5, 0);
        expc[0] = 32'd19; expc[1] = 32'd22; expc[2] = 32'd43; expc[3] = 32'd50;
        start_job(4'd2);
        load(8, 1'b0);
        chk("t1_B00", slot(B_matrix, 0), 32'd5);
        chk("t1_B01", slot(B_matrix, 1), 32'd7);
        chk("t1_B10", slot(B_matrix, 6), 32'd6);
        chk("t1_B11", slot(B_matrix, 7), 32'd8);
        chk("t1_A01", slot(A_matrix, 1), 32'd2);
        chk("t1_A10", slot(A_matrix, 6), 32'd3);
        kick_wait(2, 0, 1'b0);
        drain(2, 1'b0, 1'b0);

        // 2: full size with random input gaps and heavy output backpressure.
        @(negedge clk);
        prep(6, 100, 200, 32'h1000);
        job(6, 1'b1, 1'b1, 0, 1'b0);

        // 3: illegal sizes flag err and stay idle; a legal one then runs.
        @(negedge clk);
        start_job(4'd0);
        chk("err0", 32'(err), 32'd1);
        chk("err0_busy", 32'(busy), 32'd0);
        chk("err0_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("err0_lo", 32'(err), 32'd0);
        start_job(4'd7);
        chk("err7", 32'(err), 32'd1);
        chk("err7_busy", 32'(busy), 32'd0);
        chk("err7_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        prep(3, 10, 20, 300);
        job(3, 1'b0, 1'b0, 0, 1'b0);
        chk("t3_noerr", 32'(err), 32'd0);

        // 4 + 6: N=3 with commands during WAIT/DRAIN and GLOBAL_DONE held through the drain.
        @(negedge clk);
        prep(3, 7, 70, 900);
        job(3, 1'b1, 1'b1, 3, 1'b1);

        // 5: reset in the middle of LOAD_B.
        @(negedge clk);
        prep(6, 40, 80, 0);
        sc = start_cnt;
        start_job(4'd6);
        load(36 + 4, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("r5_busy", 32'(busy), 32'd0);
        chk("r5_ready", 32'(in_ready), 32'd0);
        chk("r5_A", 32'(A_matrix == '0), 32'd1);
        chk("r5_B", 32'(B_matrix == '0), 32'd1);
        chk("r5_start", 32'(START), 32'd0);
        chk("r5_ov", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("r5_idle", 32'(busy), 32'd0);
        chk("r5_ready2", 32'(in_ready), 32'd0);
        chk("r5_nostart", 32'(start_cnt - sc), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
